// File: rtl/alu_acc_stage_pkg.sv
// Shared opcode constants, default datapath width and buffer state type for alu_acc_stage.
package alu_acc_stage_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] ALU_OP_NOP  = 4'd0;
    localparam logic [3:0] ALU_OP_LOAD = 4'd1;
    localparam logic [3:0] ALU_OP_OR   = 4'd2;
    localparam logic [3:0] ALU_OP_AND  = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_NOT  = 4'd5;
    localparam logic [3:0] ALU_OP_ADD  = 4'd6;
    localparam logic [3:0] ALU_OP_SUB  = 4'd7;
    localparam logic [3:0] ALU_OP_CLR  = 4'd8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Opcodes 9-15 behave like NOP, so only LOAD..CLR touch any state.
    function automatic logic is_active_op(input logic [3:0] op);
        return (op >= ALU_OP_LOAD) && (op <= ALU_OP_CLR);
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational result/flag generator for alu_acc_stage: bitwise units, adder and opcode select.
// ALU_ACC_OVF_FLAG_EN adds a signed-overflow output for ADD/SUB.
module alu_logic_unit
    import alu_acc_stage_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ALU_ACC_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] or16_res;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] xor_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign or16_res = a | b;
    assign and_res  = a & b;
    assign xor_res  = a ^ b;
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};

    // SUB reports not-borrow, so carry is set when a >= b unsigned.
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            ALU_OP_LOAD: result = b;
            ALU_OP_OR:   result = or16_res;
            ALU_OP_AND:  result = and_res;
            ALU_OP_XOR:  result = xor_res;
            ALU_OP_NOT:  result = ~a;
            ALU_OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = ~diff[WIDTH];
            end
            ALU_OP_CLR:  result = '0;
            default:     result = a;
        endcase
    end

`ifdef ALU_ACC_OVF_FLAG_EN
    always_comb begin
        ovf = 1'b0;
        case (op)
            ALU_OP_ADD: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            ALU_OP_SUB: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default:    ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_acc_stage.sv
// Registered accumulator stage with a one-entry valid/ready result buffer and accepted-command counter.
// ALU_ACC_OVF_FLAG_EN adds the registered out_ovf flag.
module alu_acc_stage
    import alu_acc_stage_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
`ifdef ALU_ACC_OVF_FLAG_EN
    output logic             out_ovf,
`endif
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    buf_state_t       state;
    buf_state_t       state_next;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
`ifdef ALU_ACC_OVF_FLAG_EN
    logic             alu_ovf;
`endif

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign load      = accept && is_active_op(in_op);

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic (
        .op     (in_op),
        .a      (acc),
        .b      (in_b),
        .result (alu_result),
        .carry  (alu_carry)
`ifdef ALU_ACC_OVF_FLAG_EN
        ,
        .ovf    (alu_ovf)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A new result always wins over a simultaneous drain, keeping the buffer full.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_carry <= 1'b0;
`ifdef ALU_ACC_OVF_FLAG_EN
            out_ovf   <= 1'b0;
`endif
            op_count  <= '0;
        end else if (load) begin
            acc       <= alu_result;
            out_data  <= alu_result;
            out_zero  <= (alu_result == '0);
            out_neg   <= alu_result[WIDTH-1];
            out_carry <= alu_carry;
`ifdef ALU_ACC_OVF_FLAG_EN
            out_ovf   <= alu_ovf;
`endif
            op_count  <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_acc_stage.sv
// Self-checking bench for alu_acc_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_alu_acc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_carry;
`ifdef ALU_ACC_OVF_FLAG_EN
    logic        out_ovf;
`endif
    logic [15:0] acc;
    logic [7:0]  op_count;

    int checks;
    int errors;

    // behavioural model state
    logic [15:0] m_acc;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_zero;
    logic        m_neg;
    logic        m_carry;
    logic        m_ovf;
    logic [7:0]  m_count;
    logic        m_started;

    alu_acc_stage #(
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_carry (out_carry),
`ifdef ALU_ACC_OVF_FLAG_EN
        .out_ovf   (out_ovf),
`endif
        .acc       (acc),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op,
                                 input logic [15:0] b, input logic rdy);
        rst       = r;
        in_valid  = v;
        in_op     = op;
        in_b      = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the architectural effect of each clock edge, computed with plain arithmetic.
    always @(posedge clk) begin
        int sa, sb, sr;
        logic [15:0] res;
        logic c, o;
        m_started = 1'b1;
        if (rst) begin
            m_acc = 0; m_valid = 0; m_data = 0; m_zero = 0;
            m_neg = 0; m_carry = 0; m_ovf = 0; m_count = 0;
        end else if (in_valid && (!m_valid || out_ready) && in_op >= 1 && in_op <= 8) begin
            sa = int'($signed(m_acc));
            sb = int'($signed(in_b));
            c = 0; o = 0; res = m_acc;
            case (in_op)
                1: res = in_b;
                2: res = m_acc | in_b;
                3: res = m_acc & in_b;
                4: res = m_acc ^ in_b;
                5: res = ~m_acc;
                6: begin
                    res = 16'(int'(m_acc) + int'(in_b));
                    c = (int'(m_acc) + int'(in_b)) > 65535;
                    sr = sa + sb;
                    o = (sr > 32767) || (sr < -32768);
                end
                7: begin
                    res = 16'(int'(m_acc) - int'(in_b));
                    c = m_acc >= in_b;
                    sr = sa - sb;
                    o = (sr > 32767) || (sr < -32768);
                end
                default: res = 16'h0000;
            endcase
            m_acc = res; m_data = res; m_zero = (res == 0); m_neg = res[15];
            m_carry = c; m_ovf = o; m_valid = 1; m_count = m_count + 8'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    end

    // Continuous comparison half a cycle away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            checkOutput("acc", {16'd0, acc}, {16'd0, m_acc});
            checkOutput("op_count", {24'd0, op_count}, {24'd0, m_count});
            if (m_valid) begin
                checkOutput("out_data", {16'd0, out_data}, {16'd0, m_data});
                checkOutput("flags", {28'd0, out_zero, out_neg, out_carry, 1'b0},
                            {28'd0, m_zero, m_neg, m_carry, 1'b0});
`ifdef ALU_ACC_OVF_FLAG_EN
                checkOutput("out_ovf", {31'd0, out_ovf}, {31'd0, m_ovf});
`endif
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_started = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_b = 16'd0; out_ready = 1'b1;

        // reset held two cycles with a command offered
        applyStimulus(1, 1, 4'd1, 16'h0005, 1);
        applyStimulus(1, 1, 4'd1, 16'h0005, 1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_acc", {16'd0, acc}, 32'd0);
        checkOutput("rst_op_count", {24'd0, op_count}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // LOAD then OR on consecutive cycles
        applyStimulus(0, 1, 4'd1, 16'h0E05, 1);
        checkOutput("load_data", {16'd0, out_data}, 32'h0E05);
        checkOutput("load_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(0, 1, 4'd2, 16'h667B, 1);
        checkOutput("or_data", {16'd0, out_data}, 32'h6E7F);
        checkOutput("or_zero_neg", {30'd0, out_zero, out_neg}, 32'd0);
        checkOutput("or_count", {24'd0, op_count}, 32'd2);

        // ADD wraps to zero with carry; SUB from zero borrows
        applyStimulus(0, 1, 4'd1, 16'hFFFF, 1);
        applyStimulus(0, 1, 4'd6, 16'h0001, 1);
        checkOutput("add_data", {16'd0, out_data}, 32'h0000);
        checkOutput("add_zero_carry", {30'd0, out_zero, out_carry}, 32'd3);
        applyStimulus(0, 1, 4'd8, 16'h1111, 1);
        applyStimulus(0, 1, 4'd7, 16'h0001, 1);
        checkOutput("sub_data", {16'd0, out_data}, 32'hFFFF);
        checkOutput("sub_neg_carry", {30'd0, out_neg, out_carry}, 32'd2);
`ifdef ALU_ACC_OVF_FLAG_EN
        applyStimulus(0, 1, 4'd1, 16'h7FFF, 1);
        applyStimulus(0, 1, 4'd6, 16'h0001, 1);
        checkOutput("add_ovf", {31'd0, out_ovf}, 32'd1);
`endif

        // backpressure: result held while the consumer stalls
        applyStimulus(0, 1, 4'd1, 16'h1234, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 4'd4, 16'h00FF, 0);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_data", {16'd0, out_data}, 32'h1234);
            checkOutput("stall_acc", {16'd0, acc}, 32'h1234);
        end
        applyStimulus(0, 1, 4'd4, 16'h00FF, 1);
        checkOutput("drain_xor_data", {16'd0, out_data}, 32'h12CB);
        checkOutput("drain_xor_valid", {31'd0, out_valid}, 32'd1);

        // NOP while draining empties the buffer; op 12 changes nothing
        applyStimulus(0, 1, 4'd0, 16'hAAAA, 1);
        checkOutput("nop_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("nop_acc", {16'd0, acc}, 32'h12CB);
        applyStimulus(0, 1, 4'd12, 16'hAAAA, 1);
        checkOutput("op12_acc", {16'd0, acc}, 32'h12CB);
        checkOutput("op12_valid", {31'd0, out_valid}, 32'd0);

        // reset while full and stalled
        applyStimulus(0, 1, 4'd1, 16'h5555, 1);
        applyStimulus(0, 0, 4'd0, 16'h0000, 0);
        applyStimulus(1, 0, 4'd0, 16'h0000, 0);
        checkOutput("rst_full_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_full_acc", {16'd0, acc}, 32'd0);

        // 256 accepted commands wrap the counter
        for (int i = 0; i < 256; i++) begin
            applyStimulus(0, 1, 4'($urandom_range(1, 8)), 16'($urandom), 1);
        end
        checkOutput("count_wrap", {24'd0, op_count}, 32'd0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          4'($urandom), 16'($urandom), $urandom_range(0, 2) != 0);
        end

        applyStimulus(0, 0, 4'd0, 16'd0, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
